// File: rtl/bus_pkg.sv
// bus_pkg: shared types, default sizes and source indices for the bus arbiter
package bus_pkg;
  typedef enum logic {IDLE, HOLD} state_t;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_N = 24;
  localparam int IDX_R0 = 0;
  localparam int IDX_R1 = 1;
  localparam int IDX_R2 = 2;
  localparam int IDX_R3 = 3;
  localparam int IDX_R4 = 4;
  localparam int IDX_R5 = 5;
  localparam int IDX_R6 = 6;
  localparam int IDX_R7 = 7;
  localparam int IDX_R8 = 8;
  localparam int IDX_R9 = 9;
  localparam int IDX_R10 = 10;
  localparam int IDX_R11 = 11;
  localparam int IDX_R12 = 12;
  localparam int IDX_R13 = 13;
  localparam int IDX_R14 = 14;
  localparam int IDX_R15 = 15;
  localparam int IDX_HI = 16;
  localparam int IDX_LO = 17;
  localparam int IDX_ZHI = 18;
  localparam int IDX_ZLO = 19;
  localparam int IDX_PC = 20;
  localparam int IDX_MDR = 21;
  localparam int IDX_INPORT = 22;
  localparam int IDX_C = 23;
endpackage

// File: rtl/bus_arbiter_mux_if.sv
// bus_arbiter_mux_if: request/data sources in, registered granted bus out
interface bus_arbiter_mux_if #(
  parameter int WIDTH = 32,
  parameter int N = 24
);
  localparam int SELW = $clog2(N);
  logic [N-1:0] req;
  logic [N*WIDTH-1:0] data_in;
  logic ready;
  logic conflict_clr;
  logic [WIDTH-1:0] bus_out;
  logic bus_valid;
  logic [N-1:0] grant;
  logic [SELW-1:0] grant_idx;
  logic conflict;
  modport master (
    input req, data_in, ready, conflict_clr,
    output bus_out, bus_valid, grant, grant_idx, conflict
  );
  modport slave (
    output req, data_in, ready, conflict_clr,
    input bus_out, bus_valid, grant, grant_idx, conflict
  );
endinterface

// File: rtl/bus_arbiter_mux_rr_pick.sv
// rr_pick: find-first-set over req, optionally starting at ptr and wrapping
module rr_pick #(
  parameter int N = 24,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [SELW-1:0] ptr_i,
  input  logic            mode_i,
  output logic [N-1:0]    onehot_o,
  output logic [SELW-1:0] idx_o,
  output logic            any_o
);
  logic found;
  assign any_o = |req_i;
  assign onehot_o = any_o ? N'(1) << idx_o : '0;
  // first pass honours the pointer in round-robin mode; second pass wraps to the lowest index
  always_comb begin
    found = 1'b0;
    idx_o = '0;
    for (int i = 0; i < N; i++)
      if (!found && req_i[i] && (!mode_i || i >= int'(ptr_i))) begin
        idx_o = SELW'(i);
        found = 1'b1;
      end
    for (int i = 0; i < N; i++)
      if (!found && req_i[i]) begin
        idx_o = SELW'(i);
        found = 1'b1;
      end
  end
endmodule

// File: rtl/bus_arbiter_mux.sv
// bus_arbiter_mux: arbitrates N sources onto one registered valid/ready bus
module bus_arbiter_mux
  import bus_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N = DEF_N,
  parameter int RR_MODE = 0
) (
  input logic clk,
  input logic clr,
  bus_arbiter_mux_if.master bus
);
  localparam int SELW = $clog2(N);
  state_t state_q;
  logic [WIDTH-1:0] bus_out_q;
  logic bus_valid_q;
  logic [N-1:0] grant_q;
  logic [SELW-1:0] grant_idx_q;
  logic [SELW-1:0] ptr_q;
  logic [SELW-1:0] ptr_d;
  logic conflict_q;
  logic accept;
  logic arb;
  logic [N-1:0] pick_onehot;
  logic [SELW-1:0] pick_idx;
  logic pick_any;
  assign accept = (state_q == HOLD) && bus.ready;
  assign arb = (state_q == IDLE) || accept;
  assign ptr_d = accept ? (grant_idx_q == SELW'(N - 1) ? '0 : grant_idx_q + 1'b1) : ptr_q;
  rr_pick #(.N(N)) u_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_d),
    .mode_i  (RR_MODE != 0),
    .onehot_o(pick_onehot),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );
  // FSM: capture the winner at each arbitration point, hold it until accepted
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= IDLE;
      bus_out_q <= '0;
      bus_valid_q <= 1'b0;
      grant_q <= '0;
      grant_idx_q <= '0;
      ptr_q <= '0;
      conflict_q <= 1'b0;
    end else begin
      if (arb && pick_any) begin
        state_q <= HOLD;
        bus_out_q <= bus.data_in[int'(pick_idx)*WIDTH +: WIDTH];
        bus_valid_q <= 1'b1;
        grant_q <= pick_onehot;
        grant_idx_q <= pick_idx;
      end else if (arb) begin
        state_q <= IDLE;
        bus_valid_q <= 1'b0;
        grant_q <= '0;
      end
      ptr_q <= ptr_d;
      conflict_q <= (arb && $countones(bus.req) > 1) || (conflict_q && !bus.conflict_clr);
    end
  end
  assign bus.bus_out = bus_out_q;
  assign bus.bus_valid = bus_valid_q;
  assign bus.grant = grant_q;
  assign bus.grant_idx = grant_idx_q;
  assign bus.conflict = conflict_q;
endmodule

// File: tb/tb_bus_arbiter_mux.sv
// tb_bus_arbiter_mux: directed plan plus random traffic against a behavioural model, both modes
module tb_bus_arbiter_mux;
  localparam int W = 32;
  localparam int N = 24;
  logic clk = 1'b0;
  logic clr;
  logic [N-1:0] req;
  logic [N*W-1:0] data_in;
  logic ready;
  logic cclr;
  int checks = 0;
  int failures = 0;
  bit m_valid [2];
  int m_owner [2];
  int m_ptr [2];
  bit m_conf [2];
  logic [W-1:0] m_word [2];
  bus_arbiter_mux_if #(.WIDTH(W), .N(N)) if0 ();
  bus_arbiter_mux_if #(.WIDTH(W), .N(N)) if1 ();
  assign if0.req = req;
  assign if0.data_in = data_in;
  assign if0.ready = ready;
  assign if0.conflict_clr = cclr;
  assign if1.req = req;
  assign if1.data_in = data_in;
  assign if1.ready = ready;
  assign if1.conflict_clr = cclr;
  bus_arbiter_mux #(.WIDTH(W), .N(N), .RR_MODE(0)) dut0 (.clk(clk), .clr(clr), .bus(if0.master));
  bus_arbiter_mux #(.WIDTH(W), .N(N), .RR_MODE(1)) dut1 (.clk(clk), .clr(clr), .bus(if1.master));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int pick(input logic [N-1:0] r, input int start, input bit rr);
    for (int k = 0; k < N; k++) begin
      int j = rr ? (start + k) % N : k;
      if (r[j]) return j;
    end
    return -1;
  endfunction
  task automatic model_step(input int m);
    bit acc = m_valid[m] && ready;
    bit point = !m_valid[m] || acc;
    int np = acc ? (m_owner[m] + 1) % N : m_ptr[m];
    if (!clr) begin
      m_valid[m] = 0; m_owner[m] = 0; m_ptr[m] = 0; m_conf[m] = 0; m_word[m] = '0;
      return;
    end
    m_conf[m] = (point && $countones(req) > 1) || (m_conf[m] && !cclr);
    if (point) begin
      int w = pick(req, np, m == 1);
      m_valid[m] = w >= 0;
      if (w >= 0) begin
        m_owner[m] = w;
        m_word[m] = data_in[w*W +: W];
      end
    end
    m_ptr[m] = np;
  endtask
  task automatic compare(input int m, input logic [W-1:0] bo, input logic bv, input logic [N-1:0] g,
                         input logic [4:0] gi, input logic c);
    string s = m == 1 ? "rr" : "prio";
    check({s, "_valid"}, 64'(bv), 64'(m_valid[m]));
    check({s, "_grant"}, 64'(g), m_valid[m] ? 64'(1) << m_owner[m] : 64'(0));
    check({s, "_conflict"}, 64'(c), 64'(m_conf[m]));
    if (m_valid[m]) begin
      check({s, "_bus_out"}, 64'(bo), 64'(m_word[m]));
      check({s, "_grant_idx"}, 64'(gi), 64'(m_owner[m]));
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare(0, if0.bus_out, if0.bus_valid, if0.grant, if0.grant_idx, if0.conflict);
    compare(1, if1.bus_out, if1.bus_valid, if1.grant, if1.grant_idx, if1.conflict);
  endtask
  task automatic set_src(input int i, input logic [W-1:0] v);
    data_in[i*W +: W] = v;
  endtask
  task automatic do_reset();
    clr = 1'b0;
    cycle();
    clr = 1'b1;
  endtask
  initial begin
    int seq [6] = '{2, 7, 20, 2, 7, 20};
    clr = 1'b0; req = '0; data_in = '0; ready = 1'b0; cclr = 1'b0;
    do_reset();
    check("rst_bus_out", 64'(if1.bus_out), 64'h0);
    check("rst_grant_idx", 64'(if1.grant_idx), 64'h0);
    // reset in the middle of a held word
    req = N'(1) << 5; set_src(5, 32'hDEAD_BEEF);
    cycle();
    check("hold_r5", 64'(if0.bus_out), 64'hDEAD_BEEF);
    req = '0;
    do_reset();
    check("midhold_rst_valid", 64'(if0.bus_valid), 64'h0);
    check("midhold_rst_bus", 64'(if1.bus_out), 64'h0);
    check("midhold_rst_grant", 64'(if1.grant), 64'h0);
    cycle(); cycle();
    check("post_rst_idle", 64'(if1.bus_valid), 64'h0);
    // single request from MDR
    req = N'(1) << 21; set_src(21, 32'h1234_5678); ready = 1'b1;
    cycle();
    check("mdr_bus", 64'(if0.bus_out), 64'h1234_5678);
    check("mdr_idx", 64'(if1.grant_idx), 64'd21);
    check("mdr_conf", 64'(if0.conflict), 64'h0);
    req = '0;
    cycle();
    check("mdr_done", 64'(if0.bus_valid), 64'h0);
    // backpressure: captured word survives source changes
    req = N'(1) << 3; set_src(3, 32'hA5A5_A5A5); ready = 1'b0;
    cycle();
    set_src(3, 32'h0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("bp_hold", 64'(if1.bus_out), 64'hA5A5_A5A5);
    end
    ready = 1'b1; req = '0;
    cycle();
    check("bp_release", 64'(if1.bus_valid), 64'h0);
    // priority vs round robin on a constant triple request
    do_reset();
    req = (N'(1) << 2) | (N'(1) << 7) | (N'(1) << 20);
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("prio_seq", 64'(if0.grant_idx), 64'd2);
      check("rr_seq", 64'(if1.grant_idx), 64'(seq[k]));
      check("rr_nobubble", 64'(if1.bus_valid), 64'h1);
    end
    // wrap and sticky conflict
    do_reset();
    req = N'(1) << 22;
    cycle();
    req = (N'(1) << 23) | N'(1);
    cycle();
    check("wrap_23", 64'(if1.grant_idx), 64'd23);
    check("wrap_conf", 64'(if1.conflict), 64'h1);
    cycle();
    check("wrap_0", 64'(if1.grant_idx), 64'd0);
    cclr = 1'b1;
    cycle();
    check("conf_set_wins", 64'(if1.conflict), 64'h1);
    req = N'(1) << 5;
    cycle();
    check("conf_cleared", 64'(if1.conflict), 64'h0);
    cclr = 1'b0;
    // random traffic
    for (int k = 0; k < 3000; k++) begin
      int r = $urandom_range(0, 9);
      req = r < 2 ? '0 : r < 5 ? N'(1) << $urandom_range(0, N - 1) : N'($urandom);
      for (int i = 0; i < N; i++) set_src(i, $urandom);
      ready = $urandom_range(0, 3) != 0;
      cclr = $urandom_range(0, 7) == 0;
      clr = $urandom_range(0, 99) != 0;
      cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_arbiter_mux.md
Name: bus_arbiter_mux

Overview:
- Parametrised, registered successor to the datapath bus multiplexer.
- Arbitrates among N request-driven sources, each WIDTH bits wide, and drives one registered bus with a valid/ready handshake.
- Supports fixed-priority or round-robin selection and flags multi-source conflicts.
- Sits between register-file/special-register outputs (R0–R15, HI, LO, ZHI, ZLO, PC, MDR, INPORT, C) and datapath consumers.

Parameters:
- WIDTH, 32, bit width of each source and of the bus.
- N, 24, number of sources; legal range 2..32.
- RR_MODE, 0, arbitration mode: 0 = fixed priority (lowest index wins); 1 = round-robin.
- SELW, $clog2(N), index width; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  synchronous reset, active-low.
- req  input  N  per-source request; bit i means source i wants the bus.
- data_in  input  N*WIDTH  flattened sources; source i occupies bits [i*WIDTH +: WIDTH].
- ready  input  1  consumer accepts bus_out this cycle when bus_valid=1.
- conflict_clr  input  1  clears the sticky conflict flag.
- bus_out  output  WIDTH  registered bus data.
- bus_valid  output  1  bus_out holds a granted word.
- grant  output  N  one-hot owner of the current word; all zero when idle.
- grant_idx  output  SELW  binary index of the owner.
- conflict  output  1  sticky: more than one req bit was high at an arbitration point.

Behaviour:
- Reset (clr=0 at a clk edge):
  - bus_out=0, bus_valid=0, grant=0, grant_idx=0, conflict=0, RR pointer=0, FSM=IDLE.
  - Reset overrides every other input, including mid-HOLD. The pending word is dropped and not replayed.
- FSM states: IDLE, HOLD.
- Arbitration point: in IDLE, or in HOLD on the cycle with bus_valid & ready.
  - If req≠0: pick a winner, capture its data_in into bus_out, set grant/grant_idx, set bus_valid=1, go to HOLD.
  - Latency is 1 cycle from req to bus_valid.
  - If req==0: clear bus_valid and grant; go or stay in IDLE.
- HOLD without ready: bus_out, grant, grant_idx and bus_valid are stable. Source data changes are ignored because the word was captured at grant.
- Back-to-back transfers: on an accept, a new winner loads in the same edge, so bus_valid stays 1 with no bubble.
- Source protocol: the granted source deasserts its req after the accept cycle (grant & ready). If it keeps req high, it re-enters arbitration as a new request.
- Priority mode: winner is the lowest set index of req.
- Round-robin mode:
  - Winner is the first set bit at or above ptr, wrapping from N-1 to 0.
  - On each accept, ptr ← winner_idx+1, wrapping N-1 → 0.
  - ptr does not change while a word is unaccepted.
- Conflict:
  - Set when popcount(req)>1 at an arbitration point where a grant is issued.
  - Cleared by conflict_clr=1.
  - Set and clear in the same cycle: set wins.
- req bits at or above N do not exist. grant_idx never exceeds N-1.

Decomposition:
- Shared package bus_pkg:
  - state enum {IDLE, HOLD}.
  - Default WIDTH/N constants.
  - Source index localparams (IDX_R0..IDX_R15, IDX_HI=16, IDX_LO=17, IDX_ZHI=18, IDX_ZLO=19, IDX_PC=20, IDX_MDR=21, IDX_INPORT=22, IDX_C=23).
- One sub-module: rr_pick.
  - Combinational N-bit masked find-first-set.
  - Inputs: req, ptr, mode. Outputs: one-hot, index, any.
  - Instantiated once. The top holds the FSM, data capture and conflict flag.

Test Plan:
- Reset mid-HOLD: grant R5 (data 0xDEAD_BEEF), ready=0, pull clr low one cycle → next cycle all outputs 0, state IDLE; after release with req=0, bus_valid stays 0.
- Single request: req[21]=1 (MDR=0x1234_5678), ready=1 → one cycle later bus_out=0x1234_5678, grant_idx=21, grant=1<<21, bus_valid=1; conflict stays 0.
- Backpressure: grant R3=0xA5A5_A5A5, ready=0 for 4 cycles while data_in R3 changes to 0 → bus_out holds 0xA5A5_A5A5 and grant is stable; ready=1 accepts; with req=0, bus_valid=0 next cycle.
- Priority vs RR: req={R2,R7,R20} held constant, ready=1, 6 accepts.
  - RR_MODE=0: grant_idx 2,2,2,... with no bubbles.
  - RR_MODE=1: grant_idx 2,7,20,2,7,20.
- Wrap and conflict: RR_MODE=1, ptr brought to 23, req={R23,R0} → grants 23 then 0; conflict=1 after the first grant; conflict_clr asserted together with a new double request → conflict stays 1; conflict_clr with a single request → conflict=0.
